// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_queue_pkg                                              |
// | Description : Shared fetch-path types and default sizing.                  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package fetch_queue_pkg;

    localparam int FQ_PC_W  = 8;
    localparam int FQ_DEPTH = 4;

    typedef logic [FQ_PC_W-1:0] ProgramCounter;
    typedef logic [31:0]        Instruction;

endpackage
`default_nettype wire

// File: rtl/fetch_queue_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_queue_mem                                              |
// | Description : Prefetch storage, one sync write port, one async read port.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module fetch_queue_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 40
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    // Contents are deliberately unreset; the queue occupancy masks stale data.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_queue                                                  |
// | Description : Instruction prefetch queue between a comb ROM and decode.    |
// |               Optional decode bypass under FETCH_QUEUE_BYPASS_EN.          |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int PC_W  = FQ_PC_W
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [PC_W-1:0]            rom_addr,
    input  Instruction                 rom_instr,
    input  logic                       redirect,
    input  logic [PC_W-1:0]            redirect_pc,
    output logic                       out_valid,
    output Instruction                 out_instr,
    output logic [PC_W-1:0]            out_pc,
    output logic [PC_W-1:0]            out_npc,
    input  logic                       dec_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int                c_AW   = $clog2(DEPTH);
    localparam int                c_CW   = c_AW + 1;
    localparam int                c_EW   = PC_W + 32;
    localparam logic [c_CW-1:0]   c_FULL = c_CW'(DEPTH);

    logic [PC_W-1:0] r_fpc;
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic [PC_W-1:0] r_hold_pc;
    Instruction      r_hold_instr;

    logic [c_EW-1:0] w_rd_data;
    logic            w_have_head;
    logic            w_bypass;
    logic            w_pop;
    logic            w_pop_q;
    logic            w_push;
    logic            w_fpc_adv;

    assign w_have_head = (r_count != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign w_bypass = ~rst & ~w_have_head & ~redirect;
`else
    assign w_bypass = 1'b0;
`endif

    // When nothing is presented, the last presented head stays on the outputs.
    always_comb begin
        out_valid = (w_have_head & ~redirect) | w_bypass;
        out_pc    = r_hold_pc;
        out_instr = r_hold_instr;
        if (w_have_head) begin
            out_pc    = w_rd_data[c_EW-1 -: PC_W];
            out_instr = w_rd_data[31:0];
        end else if (w_bypass) begin
            out_pc    = r_fpc;
            out_instr = rom_instr;
        end
    end

    assign out_npc   = out_pc + PC_W'(1);
    assign rom_addr  = r_fpc;
    assign count     = r_count;

    assign w_pop     = out_valid & dec_ready & ~redirect;
    assign w_pop_q   = w_pop & w_have_head;
    // A bypassed instruction taken by decode never occupies an entry.
    assign w_push    = ~redirect & ((r_count < c_FULL) | w_pop) & ~(w_bypass & dec_ready);
    assign w_fpc_adv = w_push | (w_bypass & dec_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fpc    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (redirect) begin
            r_fpc    <= redirect_pc;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_fpc_adv) begin
                r_fpc <= r_fpc + PC_W'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop_q) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop_q})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_pc    <= '0;
            r_hold_instr <= '0;
        end else if (w_have_head | w_bypass) begin
            r_hold_pc    <= out_pc;
            r_hold_instr <= out_instr;
        end
    end

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (c_EW)
    ) u_mem (
        .clk   (clk),
        .we    (w_push),
        .waddr (r_wr_ptr),
        .wdata ({r_fpc, rom_instr}),
        .raddr (r_rd_ptr),
        .rdata (w_rd_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fetch_queue                                               |
// | Description : Directed + random bench for fetch_queue with a queue model.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = FQ_DEPTH;
    localparam int PC_W  = FQ_PC_W;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst;
    ProgramCounter   rom_addr;
    Instruction      rom_instr;
    logic            redirect;
    ProgramCounter   redirect_pc;
    logic            out_valid;
    Instruction      out_instr;
    ProgramCounter   out_pc;
    ProgramCounter   out_npc;
    logic            dec_ready;
    logic [CW-1:0]   count;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    typedef struct {
        ProgramCounter pc;
        Instruction    instr;
    } ent_t;

    ent_t          q[$];
    ProgramCounter m_fpc;
    ProgramCounter m_last_pc;
    Instruction    m_last_instr;

    logic          s_valid;
    ProgramCounter s_pc;
    ProgramCounter s_npc;
    logic [CW-1:0] s_count;
    ProgramCounter s_rom;

    always #5 clk = ~clk;

    function automatic Instruction rom_of(input ProgramCounter pc);
        return 32'h1000_0000 + 32'(pc);
    endfunction

    assign rom_instr = rom_of(rom_addr);

    fetch_queue #(
        .DEPTH (DEPTH),
        .PC_W  (PC_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rom_addr    (rom_addr),
        .rom_instr   (rom_instr),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_npc     (out_npc),
        .dec_ready   (dec_ready),
        .count       (count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        m_fpc        = '0;
        m_last_pc    = '0;
        m_last_instr = '0;
    endfunction

    // One cycle: drive inputs, check all outputs against the model, then advance.
    task automatic step(input logic r, input ProgramCounter rpc, input logic dr);
        logic          byp;
        logic          mvalid;
        logic          pop;
        logic          can_push;
        ProgramCounter epc;
        Instruction    ein;
        redirect    = r;
        redirect_pc = rpc;
        dec_ready   = dr;
        #1;
        byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = (q.size() == 0) && !r;
`endif
        mvalid = ((q.size() > 0) && !r) || byp;
        if (q.size() > 0) begin
            epc = q[0].pc;
            ein = q[0].instr;
        end else if (byp) begin
            epc = m_fpc;
            ein = rom_of(m_fpc);
        end else begin
            epc = m_last_pc;
            ein = m_last_instr;
        end
        chk("out_valid", 32'(out_valid), 32'(mvalid));
        chk("out_pc",    32'(out_pc),    32'(epc));
        chk("out_instr", out_instr,      ein);
        chk("out_npc",   32'(out_npc),   32'(ProgramCounter'(epc + 8'd1)));
        chk("count",     32'(count),     32'(q.size()));
        chk("rom_addr",  32'(rom_addr),  32'(m_fpc));
        s_valid = out_valid;
        s_pc    = out_pc;
        s_npc   = out_npc;
        s_count = count;
        s_rom   = rom_addr;

        if ((q.size() > 0) || byp) begin
            m_last_pc    = epc;
            m_last_instr = ein;
        end
        if (r) begin
            q.delete();
            m_fpc = rpc;
        end else begin
            pop = mvalid && dr;
            if (byp && pop) begin
                m_fpc = m_fpc + 8'd1;
            end else begin
                can_push = (q.size() < DEPTH) || pop;
                if (pop) void'(q.pop_front());
                if (can_push) begin
                    q.push_back('{m_fpc, rom_of(m_fpc)});
                    m_fpc = m_fpc + 8'd1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        redirect  = 1'b0;
        dec_ready = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count),     32'd0);
        chk("rst_pc",    32'(out_pc),    32'd0);
        chk("rst_instr", out_instr,      32'd0);
        chk("rst_rom",   32'(rom_addr),  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        ProgramCounter pcs[$];
        int            seen;
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        dec_ready   = 1'b0;
        model_reset();

        // Reset release with decode always ready.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 8'h00, 1'b1);
`ifdef FETCH_QUEUE_BYPASS_EN
            chk("byp_valid", 32'(s_valid), 32'd1);
            chk("byp_pc",    32'(s_pc),    32'(i));
            chk("byp_count", 32'(s_count), 32'd0);
`else
            if (i == 0) chk("first_bubble", 32'(s_valid), 32'd0);
            else        chk("stream_pc",    32'(s_pc),    32'(i - 1));
`endif
        end

        // Back-pressure until full, then drain.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0);
        chk("full_count", 32'(s_count), 32'(DEPTH));
        chk("full_rom",   32'(s_rom),   32'(DEPTH));
        for (int i = 0; i <= DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("drain_pc",    32'(s_pc),    32'(i));
            chk("drain_valid", 32'(s_valid), 32'd1);
        end

        // Redirect with three entries queued.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h40, 1'b1);
        chk("redir_valid", 32'(s_valid), 32'd0);
        chk("redir_count", 32'(s_count), 32'd3);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b1);
            if (s_valid) begin
                if (seen < 2) chk("redir_pc", 32'(s_pc), 32'h40 + 32'(seen));
                seen++;
            end
        end
        chk("redir_seen", 32'(seen >= 2), 32'd1);

        // PC wrap.
        step(1'b1, 8'hFE, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 8'h00, 1'b1);
            if (s_valid) begin
                pcs.push_back(s_pc);
                if (s_pc == 8'hFF) chk("wrap_npc", 32'(s_npc), 32'd0);
            end
        end
        chk("wrap_len", 32'(pcs.size() >= 3), 32'd1);
        if (pcs.size() >= 3) begin
            chk("wrap_pc0", 32'(pcs[0]), 32'hFE);
            chk("wrap_pc1", 32'(pcs[1]), 32'hFF);
            chk("wrap_pc2", 32'(pcs[2]), 32'h00);
        end

        // Asynchronous reset mid-stream with two entries queued.
        do_reset();
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("pre_rst_count", 32'(count), 32'd2);
        rst = 1'b1;
        #1;
        chk("async_valid", 32'(out_valid), 32'd0);
        chk("async_count", 32'(count),     32'd0);
        chk("async_pc",    32'(out_pc),    32'd0);
        chk("async_instr", out_instr,      32'd0);
        chk("async_rom",   32'(rom_addr),  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        step(1'b0, 8'h00, 1'b1);
        chk("restart_rom", 32'(s_rom), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 15) == 0), ProgramCounter'($urandom),
                 ($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
